// File: rtl/controlador_compuerta_param.sv
// Parametrised parking-gate access controller with edge-qualified PIN entry.
// Optional auto-close timer in ABIERTO is enabled by defining CIERRE_AUTO_EN.
module controlador_compuerta_param #(
  parameter int                PIN_W        = 8,
  parameter logic [PIN_W-1:0]  PIN_CORRECTO = 8'b00010000,
  parameter int                MAX_INTENTOS = 3,
  parameter int                CNT_W        = 2,
  parameter int                T_ABIERTO    = 64
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Vehiculo,
  input  logic             Termino,
  input  logic             enterPin,
  input  logic [PIN_W-1:0] Pin,
  output logic             Cerrado,
  output logic             Abierto,
  output logic             Alarma,
  output logic             Bloqueo,
  output logic [CNT_W-1:0] Intentos
);

  if (MAX_INTENTOS < 1 || MAX_INTENTOS > 255 ||
      MAX_INTENTOS > (2**CNT_W) - 1 || T_ABIERTO < 1) begin : g_param_err
    $error("controlador_compuerta_param: bad parameters");
  end

  typedef enum logic [2:0] {
    CERRADO    = 3'd0,
    ESPERA_PIN = 3'd1,
    ALARMA_PIN = 3'd2,
    ABIERTO    = 3'd3,
    BLOQUEO    = 3'd4
  } estado_e;

  localparam logic [CNT_W:0] MAX_C = (CNT_W+1)'(MAX_INTENTOS);

  estado_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ent_q;
  logic             ev, ok, bad;
  logic [CNT_W:0]   cnt_inc;
  logic [CNT_W-1:0] cnt_sat;

  assign ev  = enterPin & ~ent_q;
  assign ok  = ev & (Pin == PIN_CORRECTO);
  assign bad = ev & (Pin != PIN_CORRECTO);

  assign cnt_inc = {1'b0, cnt_q} + 1'b1;
  assign cnt_sat = (cnt_inc >= MAX_C) ? MAX_C[CNT_W-1:0]
                                      : cnt_inc[CNT_W-1:0];

`ifdef CIERRE_AUTO_EN
  localparam int TW = (T_ABIERTO > 1) ? $clog2(T_ABIERTO) : 1;
  localparam logic [TW-1:0] T_LOAD = TW'(T_ABIERTO - 1);

  logic [TW-1:0] tmr_q, tmr_d;
  logic          expiro;

  assign expiro = (tmr_q == '0);
`else
  logic expiro;

  assign expiro = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CERRADO: begin
        if (Vehiculo) state_d = ESPERA_PIN;
      end
      ESPERA_PIN: begin
        if (ok) begin
          state_d = ABIERTO;
          cnt_d   = '0;
        end else if (bad) begin
          cnt_d = cnt_sat;
          if (cnt_inc >= MAX_C) state_d = ALARMA_PIN;
        end
      end
      ALARMA_PIN: begin
        if (ok) begin
          state_d = ABIERTO;
          cnt_d   = '0;
        end else if (bad) begin
          cnt_d = cnt_sat;
        end
      end
      ABIERTO: begin
        unique case (1'b1)
          Vehiculo & Termino:  state_d = BLOQUEO;
          Termino & ~Vehiculo: state_d = CERRADO;
          expiro:              state_d = CERRADO;
          default:             state_d = ABIERTO;
        endcase
      end
      BLOQUEO: begin
        if (ok) begin
          state_d = ABIERTO;
          cnt_d   = '0;
        end
      end
      default: state_d = CERRADO;
    endcase
  end

`ifdef CIERRE_AUTO_EN
  // Reload on every entry to ABIERTO, count down while staying there.
  always_comb begin
    tmr_d = tmr_q;
    if (state_d == ABIERTO && state_q != ABIERTO) tmr_d = T_LOAD;
    else if (state_q == ABIERTO && !expiro)       tmr_d = tmr_q - 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) tmr_q <= '0;
    else       tmr_q <= tmr_d;
  end
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= CERRADO;
      cnt_q   <= '0;
      ent_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ent_q   <= enterPin;
    end
  end

  assign Cerrado  = (state_q == CERRADO);
  assign Abierto  = (state_q == ABIERTO);
  assign Alarma   = (state_q == ALARMA_PIN) || (state_q == BLOQUEO);
  assign Bloqueo  = (state_q == BLOQUEO);
  assign Intentos = cnt_q;

endmodule
